// File: rtl/alu8_pkg.sv
// Shared constants, opcode and FSM state types for the 8-bit sequential ALU.
package alu8_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_PASS = 3'b110,
        OP_RSV  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SERIAL,
        S_DONE
    } state_e;

    // ADD/SUB go through the bit-serial adder; everything else is one-shot.
    function automatic logic is_arith(input op_e o);
        return (o == OP_ADD) || (o == OP_SUB);
    endfunction

endpackage

// File: rtl/alu8_if.sv
// Operation request / result handshake bundle between a requester and the ALU.
interface alu8_if;
    import alu8_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero
    );

endinterface

// File: rtl/alu8_fa_bit.sv
// Combinational 1-bit full adder built from nine NAND2 cells.
module alu8_fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic n1, n2, n3, x1, n4, n5, n6;

    alu8_nand2 u_1 (.a_i(a_i), .b_i(b_i), .y_o(n1));
    alu8_nand2 u_2 (.a_i(a_i), .b_i(n1),  .y_o(n2));
    alu8_nand2 u_3 (.a_i(b_i), .b_i(n1),  .y_o(n3));
    alu8_nand2 u_4 (.a_i(n2),  .b_i(n3),  .y_o(x1));   // a ^ b
    alu8_nand2 u_5 (.a_i(x1),  .b_i(c_i), .y_o(n4));
    alu8_nand2 u_6 (.a_i(x1),  .b_i(n4),  .y_o(n5));
    alu8_nand2 u_7 (.a_i(c_i), .b_i(n4),  .y_o(n6));
    alu8_nand2 u_8 (.a_i(n5),  .b_i(n6),  .y_o(s_o));  // a ^ b ^ c
    alu8_nand2 u_9 (.a_i(n1),  .b_i(n4),  .y_o(c_o));  // ab | (a^b)c
endmodule

// File: rtl/alu8_gates.sv
// NAND-built gate library: a 2-input NAND primitive and W-bit wide logic cells.
module alu8_nand2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i & b_i);
endmodule

module alu8_not8 #(parameter int W = 8) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        alu8_nand2 u_n (.a_i(a_i[i]), .b_i(a_i[i]), .y_o(y_o[i]));
    end
endmodule

module alu8_and8 #(parameter int W = 8) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    logic [W-1:0] n;
    for (genvar i = 0; i < W; i++) begin : g_bit
        alu8_nand2 u_n0 (.a_i(a_i[i]), .b_i(b_i[i]), .y_o(n[i]));
        alu8_nand2 u_n1 (.a_i(n[i]),   .b_i(n[i]),   .y_o(y_o[i]));
    end
endmodule

module alu8_or8 #(parameter int W = 8) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    logic [W-1:0] na, nb;
    for (genvar i = 0; i < W; i++) begin : g_bit
        alu8_nand2 u_ia (.a_i(a_i[i]), .b_i(a_i[i]), .y_o(na[i]));
        alu8_nand2 u_ib (.a_i(b_i[i]), .b_i(b_i[i]), .y_o(nb[i]));
        alu8_nand2 u_o  (.a_i(na[i]),  .b_i(nb[i]),  .y_o(y_o[i]));
    end
endmodule

module alu8_xor8 #(parameter int W = 8) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    logic [W-1:0] n0, n1, n2;
    for (genvar i = 0; i < W; i++) begin : g_bit
        alu8_nand2 u_0 (.a_i(a_i[i]), .b_i(b_i[i]), .y_o(n0[i]));
        alu8_nand2 u_1 (.a_i(a_i[i]), .b_i(n0[i]),  .y_o(n1[i]));
        alu8_nand2 u_2 (.a_i(b_i[i]), .b_i(n0[i]),  .y_o(n2[i]));
        alu8_nand2 u_3 (.a_i(n1[i]),  .b_i(n2[i]),  .y_o(y_o[i]));
    end
endmodule

// File: rtl/alu8_seq.sv
// 8-bit ALU: logic ops finish in one EXEC cycle, ADD/SUB run bit-serially
// LSB first over eight SERIAL cycles through a single NAND full adder.
module alu8_seq
    import alu8_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    alu8_if.slave bus
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;          // running serial carry
    logic [WIDTH-1:0] res_q, res_d;      // result / serial sum shift register
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             rdy_q, rdy_d;
    logic             vld_q, vld_d;

    logic [WIDTH-1:0] and_w, or_w, xor_w, not_w;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] ser_next;
    logic             fa_a, fa_b, fa_s, fa_co;
    op_e              op_in;

    assign op_in = op_e'(bus.op);

    alu8_and8 #(.W(WIDTH)) u_and (.a_i(a_q), .b_i(b_q), .y_o(and_w));
    alu8_or8  #(.W(WIDTH)) u_or  (.a_i(a_q), .b_i(b_q), .y_o(or_w));
    alu8_xor8 #(.W(WIDTH)) u_xor (.a_i(a_q), .b_i(b_q), .y_o(xor_w));
    alu8_not8 #(.W(WIDTH)) u_not (.a_i(a_q), .y_o(not_w));

    // Serial adder input bit; SUB adds the inverted subtrahend.
    assign fa_a = a_q[cnt_q];
    assign fa_b = (op_q == OP_SUB) ? ~b_q[cnt_q] : b_q[cnt_q];

    alu8_fa_bit u_fa (.a_i(fa_a), .b_i(fa_b), .c_i(c_q), .s_o(fa_s), .c_o(fa_co));

    assign ser_next = {fa_s, res_q[WIDTH-1:1]};

    // Single-cycle result selection for the non-arithmetic opcodes.
    always_comb begin
        logic_res = '0;
        case (op_q)
            OP_AND:  logic_res = and_w;
            OP_OR:   logic_res = or_w;
            OP_XOR:  logic_res = xor_w;
            OP_NOT:  logic_res = not_w;
            OP_PASS: logic_res = a_q;
            default: logic_res = '0;
        endcase
    end

    // Next-state and datapath update for the IDLE/EXEC/SERIAL/DONE sequence.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        vld_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && rdy_q) begin
                    op_d    = op_in;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cnt_d   = '0;
                    c_d     = (op_in == OP_SUB);
                    state_d = is_arith(op_in) ? S_SERIAL : S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = logic_res;
                carry_d = 1'b0;
                zero_d  = (logic_res == '0);
                state_d = S_DONE;
            end
            S_SERIAL: begin
                res_d = ser_next;
                c_d   = fa_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    carry_d = fa_co;
                    zero_d  = (ser_next == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // out_valid trails DONE entry by one cycle; hold until taken.
                if (vld_q && bus.out_ready) state_d = S_IDLE;
                else                        vld_d   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        rdy_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.result    = res_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu8_seq.sv
// Bench for alu8_seq: directed vector table, random ops against a plain
// arithmetic model, plus backpressure and mid-operation reset sequences.
module tb_alu8_seq;
    import alu8_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu8_if bus();

    alu8_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, b, res,
                                input logic c, z, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.c = c; v.z = z; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: result/carry/zero and accept-to-valid latency from opcode rules.
    function automatic void model(input logic [2:0] op, input logic [7:0] a, b,
                                  output logic [7:0] r, output logic c, z, output int lat);
        logic [8:0] s;
        c = 1'b0; lat = 2; r = 8'h00;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~a;
            3'd4: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; lat = 9; end
            3'd5: begin r = a - b; c = (a >= b); lat = 9; end
            3'd6: r = a;
            default: r = 8'h00;
        endcase
        z = (r == 8'h00);
    endfunction

    // Issue one op, scramble inputs while busy, measure latency, take the result.
    task automatic do_op(input logic [2:0] op, input logic [7:0] a, b,
                         output logic [7:0] r, output logic c, z, output int lat);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            bus.in_valid = 1'($urandom);
            bus.op = 3'($urandom);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        r = bus.result; c = bus.carry; z = bus.zero;
        chk("in_ready_busy", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("out_valid_drop", bus.out_valid, 0);
        chk("in_ready_after", bus.in_ready, 1);
    endtask

    initial begin
        logic [7:0] r, er;
        logic       c, z, ec, ez;
        int         lat, elat, spur, n;
        logic [2:0] op;
        logic [7:0] a, b;

        tbl[0]  = mk(3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 2);
        tbl[1]  = mk(3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 9);
        tbl[2]  = mk(3'b100, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 9);
        tbl[3]  = mk(3'b101, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 9);
        tbl[4]  = mk(3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 9);
        tbl[5]  = mk(3'b111, 8'h5A, 8'hC3, 8'h00, 1'b0, 1'b1, 2);
        tbl[6]  = mk(3'b001, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 2);
        tbl[7]  = mk(3'b010, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 2);
        tbl[8]  = mk(3'b011, 8'h0F, 8'h99, 8'hF0, 1'b0, 1'b0, 2);
        tbl[9]  = mk(3'b110, 8'h00, 8'h77, 8'h00, 1'b0, 1'b1, 2);
        tbl[10] = mk(3'b101, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1, 9);
        tbl[11] = mk(3'b100, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 9);

        bus.in_valid = 1'b0; bus.op = 3'b000; bus.a = 8'h00; bus.b = 8'h00;
        bus.out_ready = 1'b0;

        // Reset state, before and after a clock edge under reset.
        #2;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_carry", bus.carry, 0);
        chk("rst_zero", bus.zero, 0);
        @(posedge clk); #1;
        chk("rst_in_ready_edge", bus.in_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_post_rst", bus.in_ready, 1);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, c, z, lat);
            chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
            chk($sformatf("tbl%0d_carry", i), c, tbl[i].c);
            chk($sformatf("tbl%0d_zero", i), z, tbl[i].z);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
        end

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            model(op, a, b, er, ec, ez, elat);
            do_op(op, a, b, r, c, z, lat);
            chk($sformatf("rnd%0d_result", i), r, er);
            chk($sformatf("rnd%0d_carry", i), c, ec);
            chk($sformatf("rnd%0d_zero", i), z, ez);
            chk($sformatf("rnd%0d_latency", i), lat, elat);
        end

        // Backpressure: result held in DONE while inputs churn.
        bus.in_valid = 1'b1; bus.op = 3'b010; bus.a = 8'h0F; bus.b = 8'h33;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_valid", bus.out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 8'($urandom);
            @(posedge clk); #1;
            chk("bp_result_hold", bus.result, 8'h3C);
            chk("bp_valid_hold", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_delivered", bus.result, 8'h3C);
        chk("bp_delivered_zero", bus.zero, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_valid_drop", bus.out_valid, 0);

        // Reset during SERIAL cycle 4 of an ADD.
        bus.in_valid = 1'b1; bus.op = 3'b100; bus.a = 8'hFF; bus.b = 8'h01;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_result", bus.result, 0);
        bus.out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready_back", bus.in_ready, 1);
        spur = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid !== 1'b0) spur++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_result", spur, 0);
        bus.out_ready = 1'b0;
        do_op(3'b010, 8'hAA, 8'hFF, r, c, z, lat);
        chk("post_rst_xor", r, 8'h55);
        chk("post_rst_xor_lat", lat, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu8_seq.md
ALU8_SEQ -- requirements
Module: alu8_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, operand/opcode presented.
REQ-004 SHALL have port in_ready, output, 1, block can accept an operation.
REQ-005 SHALL have port op, input, 3, opcode: 000 AND, 001 OR, 010 XOR, 011 NOT a, 100 ADD, 101 SUB (a-b), 110 PASS a, 111 reserved.
REQ-006 SHALL have ports a and b, input, 8 each, operands.
REQ-007 SHALL have port out_valid, output, 1, result available.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-009 SHALL have port result, output, 8, operation result.
REQ-010 SHALL have ports carry and zero, output, 1 each, status flags.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, SERIAL, DONE.
REQ-012 SHALL assert in_ready only in IDLE; accept = in_valid & in_ready, registering op, a and b.
REQ-013 On accept, SHALL go to SERIAL for op 100/101, else to EXEC.
REQ-014 EXEC SHALL last exactly 1 cycle, computing the bitwise/pass result combinationally from the registered operands, then go to DONE.
REQ-015 SERIAL SHALL process one bit per cycle, LSB first, for exactly 8 cycles via a 3-bit counter 0..7, then go to DONE.
REQ-016 ADD SHALL use carry-in 0; SUB SHALL compute a + ~b with carry-in 1.
REQ-017 Latency: out_valid SHALL rise 2 edges after the accept edge for logic/pass/reserved ops and 9 edges after it for ADD/SUB.
REQ-018 In DONE, out_valid SHALL be 1 and result/carry/zero SHALL hold stable until out_valid & out_ready.
REQ-019 On the out handshake, SHALL return to IDLE; in_ready rises the following cycle, with no same-cycle bypass.
REQ-020 carry SHALL equal the final carry-out for ADD, 1 = no borrow (a >= b unsigned) for SUB, and 0 for all other ops.
REQ-021 zero SHALL be 1 iff result == 8'h00, for all ops.
REQ-022 Reserved op 111 SHALL produce result 8'h00, carry 0, zero 1, and no error signalling.
REQ-023 ADD/SUB overflow SHALL wrap modulo 256.
REQ-024 in_valid and operand changes while not in IDLE SHALL be ignored.

Reset
REQ-025 While rst_n = 0: state IDLE, in_ready 0, out_valid 0, result 8'h00, carry 0, zero 0, bit counter 0.
REQ-026 in_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-027 Reset asserted mid-EXEC/SERIAL/DONE SHALL abort the operation, with no result emitted afterwards.

Structure
REQ-028 Package alu8_pkg SHALL hold the WIDTH=8 constant, the opcode enum and the FSM state enum.
REQ-029 Bitwise ops SHALL reuse the codebase's NAND-built 8-bit gate library cells.
REQ-030 One sub-module, alu8_fa_bit (NAND-built 1-bit full adder, combinational), SHALL serve the serial datapath; carry and result shift registers stay in alu8_seq.

Verification
REQ-031 AND a=0xF0 b=0x3C -> result 0x30, carry 0, zero 0, out_valid 2 edges after accept.
REQ-032 ADD 0xFF+0x01 -> result 0x00, carry 1, zero 1, out_valid 9 edges after accept; ADD 0x12+0x34 -> 0x46, carry 0.
REQ-033 SUB 0x07-0x05 -> 0x02, carry 1; SUB 0x05-0x07 -> 0xFE, carry 0.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a -> result stable, in_ready 0, and the first result is delivered intact when out_ready=1.
REQ-035 Pull rst_n low in SERIAL cycle 4 of ADD -> out_valid stays 0; after release, in_ready=1; XOR 0xAA^0xFF -> 0x55.
REQ-036 op=111 with a=0x5A -> result 0x00, zero 1, carry 0.
